ldl_sfifo_v2: RTL and testbench
===============================

LDL_SFIFO_V2 -- requirements
Module: LDL_sfifo_v2

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- DW, 8, data width.
- AW, 8, address width; RAM depth 2^AW.
- AHEAD, 0, output mode: 0 = standard (registered dout after re), 1 = first-word-fall-through (FWFT).
- AF_TH, 2^AW-2, almost_full threshold, range 1..2^AW.
- AE_TH, 1, almost_empty threshold, range 0..2^AW-1.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on rising edge.
- rst, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous clear of contents.
- we, in, 1, write request.
- din, in, DW, write data.
- re, in, 1, read/pop request.
- dout, out, DW, read data.
- empty, out, 1, no readable word.
- full, out, 1, RAM holds 2^AW words.
- almost_full, out, 1, cnt >= AF_TH.
- almost_empty, out, 1, cnt <= AE_TH.
- cnt, out, AW+1, RAM occupancy.
- overflow, out, 1, sticky: write attempted while full.
- underflow, out, 1, sticky: read attempted while empty.
- clr_err, in, 1, clears overflow/underflow.

Function
REQ-003 Write and read pointers SHALL be AW+1 bits; the MSB distinguishes full from empty on address wrap.
REQ-004 Write accept SHALL be we & ~full & ~flush; rejected writes SHALL leave RAM and pointers unchanged.
REQ-005 Read accept SHALL be re & ~empty & ~flush.
REQ-006 Full SHALL block writes even when a read is accepted in the same cycle; at empty, an accepted write and a rejected read SHALL both be handled correctly in the same cycle.
REQ-007 cnt SHALL equal wptr - rptr modulo 2^(AW+1), range 0..2^AW. full SHALL equal (cnt == 2^AW). A simultaneous accepted write and RAM read SHALL leave cnt unchanged.
REQ-008 AHEAD=0 behaviour:
- empty SHALL equal (cnt == 0).
- A write at edge N SHALL make empty=0 after edge N.
- A read accepted at edge N SHALL present the word on dout after edge N+1.
- dout SHALL hold its value until the next accepted read.
REQ-009 AHEAD=1 behaviour:
- An internal output-register valid bit (ov) SHALL prefetch from RAM whenever ov=0 or a pop occurs, provided cnt>0.
- empty SHALL equal ~ov.
- dout SHALL show the head word whenever empty=0; re with empty=0 pops it.
- Writing into a completely empty FIFO at edge N SHALL make empty=0 with dout=data after edge N+2.
- Back-to-back pops SHALL sustain one word per cycle while cnt>0.
- cnt SHALL exclude the word in the output register.
REQ-010 Ordering SHALL be strict FIFO across pointer wrap-around at all depths.
REQ-011 Error flags:
- overflow SHALL set the cycle after we & full & ~flush.
- underflow SHALL set the cycle after re & empty & ~flush.
- clr_err SHALL clear both flags; a set event in the same cycle SHALL take priority.
REQ-012 flush SHALL take priority over we and re. The edge with flush=1 SHALL:
- zero both pointers and ov;
- produce cnt=0, empty=1, full=0 on the next cycle.
It SHALL NOT alter dout, overflow or underflow.
REQ-013 almost_full and almost_empty SHALL be combinational decodes of registered pointers only; no input-to-output combinational path is permitted on any output.
REQ-014 RAM SHALL be a simple dual-port array (write port plus registered read port) inferred inside the block.

Reset
REQ-015 While rst=0, the block SHALL force asynchronously:
- pointers=0, ov=0, cnt=0;
- empty=1, full=0, almost_empty=1, almost_full=0;
- overflow=0, underflow=0, dout=0.
REQ-016 RAM contents SHALL NOT be reset.
REQ-017 Deassertion mid-traffic SHALL resume from the empty state; no request is accepted in a cycle where rst=0.

Verification
REQ-018 AW=2, AHEAD=0: write 4 words A..D -> full=1, cnt=4, almost_full=1. A 5th write -> overflow=1 next cycle, cnt stays 4. Then 4 reads -> dout A,B,C,D, each one cycle after its re.
REQ-019 AW=2, AHEAD=1: single write X into empty FIFO at edge N -> empty=0 and dout=X after edge N+2. re=1 -> empty=1 next cycle, cnt=0.
REQ-020 AW=3, both modes: continuous simultaneous we/re for 40 cycles from cnt=3 -> cnt constant 3, no flags set, output sequence equals input sequence delayed, across pointer wrap.
REQ-021 Read when empty -> underflow=1 next cycle. clr_err together with another empty read -> underflow stays 1. clr_err alone -> underflow=0.
REQ-022 Fill to cnt=5 (AW=3), then flush with we=re=1 -> next cycle cnt=0, empty=1, no write accepted.
REQ-023 Assert rst=0 asynchronously mid-burst at cnt=6 -> all outputs take REQ-015 values before the next clk edge.

Source files
------------

// File: rtl/ldl_sfifo_v2.sv
// ldl_sfifo_v2: single-clock synchronous FIFO with an inferred simple dual-port
// RAM. AHEAD=0 gives a standard registered-read FIFO; AHEAD=1 gives a
// first-word-fall-through FIFO built from a two-stage prefetch pipeline
// (RAM read register, then output register).
//
// Handshake: a write is taken on a rising edge when we=1, full=0, flush=0 and
// rst=1; a read/pop is taken when re=1, empty=0, flush=0 and rst=1. Requests
// that are not taken have no effect other than setting the sticky error flags.
module ldl_sfifo_v2 #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int AHEAD = 0,
    parameter int AF_TH = (1 << AW) - 2,
    parameter int AE_TH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          we,
    input  logic [DW-1:0] din,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   cnt,
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err
);

    localparam int          DEPTH    = 1 << AW;
    localparam bit          FWFT     = (AHEAD != 0);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] AF_C     = AF_TH[AW:0];
    localparam logic [AW:0] AE_C     = AE_TH[AW:0];
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    // Storage and state
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [DW-1:0] r_ram_q;   // registered RAM read port
    logic          r_ram_v;   // AHEAD=0: read completing next edge; AHEAD=1: stage-1 valid
    logic          r_ov;      // AHEAD=1 output register valid
    logic [DW-1:0] r_dout;
    logic          r_ovf;
    logic          r_udf;

    // Decoded control
    logic [AW:0]   w_cnt;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_pop;
    logic          w_ram_rd;
    logic          w_out_ld;
    logic          w_ovf_set;
    logic          w_udf_set;

    // Occupancy and status decodes, all from registered state
    always_comb begin
        w_cnt   = r_wptr - r_rptr;
        w_full  = (w_cnt == FULL_CNT);
        w_empty = FWFT ? ~r_ov : (w_cnt == '0);
    end

    // Accept logic, RAM read enable and output register load
    always_comb begin
        w_wr_acc  = we & ~w_full & ~flush & rst;
        w_ovf_set = we & w_full & ~flush;
        w_udf_set = re & w_empty & ~flush;
        w_pop     = re & ~w_empty & ~flush & rst;
        w_ram_rd  = 1'b0;
        w_out_ld  = 1'b0;
        if (FWFT) begin
            // Output register takes stage 1 when it is free or being popped;
            // stage 1 refills from RAM when it is free or moving forward.
            w_out_ld = r_ram_v & (~r_ov | w_pop) & ~flush;
            w_ram_rd = (w_cnt != '0) & (~r_ram_v | w_out_ld) & ~flush & rst;
        end else begin
            // A pop reads RAM now; the word reaches dout one edge later.
            w_ram_rd = w_pop;
            w_out_ld = r_ram_v & ~flush;
        end
    end

    // Write and read pointers; flush returns both to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
            if (w_ram_rd) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // RAM write port and registered read port (contents never reset)
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wptr[AW-1:0]] <= din;
        if (w_ram_rd) r_ram_q <= r_mem[r_rptr[AW-1:0]];
    end

    // Read pipeline valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_v <= 1'b0;
            r_ov    <= 1'b0;
        end else if (flush) begin
            r_ram_v <= 1'b0;
            r_ov    <= 1'b0;
        end else if (FWFT) begin
            if (w_ram_rd)      r_ram_v <= 1'b1;
            else if (w_out_ld) r_ram_v <= 1'b0;
            if (w_out_ld)      r_ov <= 1'b1;
            else if (w_pop)    r_ov <= 1'b0;
        end else begin
            r_ram_v <= w_ram_rd;
            r_ov    <= 1'b0;
        end
    end

    // Output data register; holds between loads and across flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= '0;
        end else if (w_out_ld) begin
            r_dout <= r_ram_q;
        end
    end

    // Sticky error flags; a new event wins over clr_err
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (clr_err) r_ovf <= 1'b0;
            if (w_udf_set)    r_udf <= 1'b1;
            else if (clr_err) r_udf <= 1'b0;
        end
    end

    // Output drive
    always_comb begin
        dout         = r_dout;
        empty        = w_empty;
        full         = w_full;
        cnt          = w_cnt;
        almost_full  = (w_cnt >= AF_C);
        almost_empty = (w_cnt <= AE_C);
        overflow     = r_ovf;
        underflow    = r_udf;
    end

endmodule

// File: tb/tb_ldl_sfifo_v2.sv
// tb_ldl_sfifo_v2: directed bench over four FIFO configurations
// (AW=2/3 x AHEAD=0/1). Inputs are shared and gated per selected instance;
// a queue model supplies expected read data.
module tb_ldl_sfifo_v2;

  logic       clk = 1'b0;
  logic       rst;
  logic       we, re, flush, clr_err;
  logic [7:0] din;
  int         sel;

  logic [3:0] g_we, g_re, g_flush, g_clr;
  logic [7:0] v_dout [4];
  logic [3:0] v_empty, v_full, v_af, v_ae, v_ovf, v_udf;
  logic [2:0] c0, c1;
  logic [3:0] c2, c3;

  logic [7:0] s_dout;
  logic [3:0] s_cnt;
  logic       s_empty, s_full, s_af, s_ae, s_ovf, s_udf;

  logic [7:0] exp_q[$];
  logic       due_v;
  logic [7:0] due_val;
  logic [7:0] last_pop;
  int         n_tests = 0;
  int         n_fail  = 0;

  // clock
  always #5 clk = ~clk;

  // per-instance input gating
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      g_we[k]    = we && (sel == k);
      g_re[k]    = re && (sel == k);
      g_flush[k] = flush && (sel == k);
      g_clr[k]   = clr_err && (sel == k);
    end
  end

  // view of the selected instance
  always_comb begin
    s_dout  = v_dout[sel];
    s_empty = v_empty[sel];
    s_full  = v_full[sel];
    s_af    = v_af[sel];
    s_ae    = v_ae[sel];
    s_ovf   = v_ovf[sel];
    s_udf   = v_udf[sel];
    case (sel)
      0:       s_cnt = {1'b0, c0};
      1:       s_cnt = {1'b0, c1};
      2:       s_cnt = c2;
      default: s_cnt = c3;
    endcase
  end

  ldl_sfifo_v2 #(.DW(8), .AW(2), .AHEAD(0)) u_d0 (
    .clk(clk), .rst(rst), .flush(g_flush[0]), .we(g_we[0]), .din(din), .re(g_re[0]),
    .dout(v_dout[0]), .empty(v_empty[0]), .full(v_full[0]), .almost_full(v_af[0]),
    .almost_empty(v_ae[0]), .cnt(c0), .overflow(v_ovf[0]), .underflow(v_udf[0]),
    .clr_err(g_clr[0]));
  ldl_sfifo_v2 #(.DW(8), .AW(2), .AHEAD(1)) u_d1 (
    .clk(clk), .rst(rst), .flush(g_flush[1]), .we(g_we[1]), .din(din), .re(g_re[1]),
    .dout(v_dout[1]), .empty(v_empty[1]), .full(v_full[1]), .almost_full(v_af[1]),
    .almost_empty(v_ae[1]), .cnt(c1), .overflow(v_ovf[1]), .underflow(v_udf[1]),
    .clr_err(g_clr[1]));
  ldl_sfifo_v2 #(.DW(8), .AW(3), .AHEAD(0)) u_d2 (
    .clk(clk), .rst(rst), .flush(g_flush[2]), .we(g_we[2]), .din(din), .re(g_re[2]),
    .dout(v_dout[2]), .empty(v_empty[2]), .full(v_full[2]), .almost_full(v_af[2]),
    .almost_empty(v_ae[2]), .cnt(c2), .overflow(v_ovf[2]), .underflow(v_udf[2]),
    .clr_err(g_clr[2]));
  ldl_sfifo_v2 #(.DW(8), .AW(3), .AHEAD(1)) u_d3 (
    .clk(clk), .rst(rst), .flush(g_flush[3]), .we(g_we[3]), .din(din), .re(g_re[3]),
    .dout(v_dout[3]), .empty(v_empty[3]), .full(v_full[3]), .almost_full(v_af[3]),
    .almost_empty(v_ae[3]), .cnt(c3), .overflow(v_ovf[3]), .underflow(v_udf[3]),
    .clr_err(g_clr[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock edge; model updates and read-data scoreboard
  task automatic tick();
    logic ahead, wr_acc, rd_acc, pop1;
    int   depth;
    ahead  = (sel == 1) || (sel == 3);
    depth  = (sel < 2) ? 4 : 8;
    wr_acc = we && !flush && (ahead || (exp_q.size() < depth));
    rd_acc = re && !flush && (exp_q.size() > 0);
    pop1   = re && !flush && !s_empty && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (flush) begin
      exp_q.delete();
      due_v = 1'b0;
    end else begin
      if (!ahead) begin
        if (due_v) begin
          chk("dout_seq", s_dout, due_val);
          last_pop = due_val;
        end
        due_v = rd_acc;
        if (rd_acc) due_val = exp_q.pop_front();
      end else if (pop1) begin
        void'(exp_q.pop_front());
      end
      if (wr_acc) exp_q.push_back(din);
      if (ahead && !s_empty && exp_q.size() > 0) chk("dout_head", s_dout, exp_q[0]);
    end
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; flush = 1'b0; clr_err = 1'b0; din = '0;
    sel = 0; due_v = 1'b0; due_val = '0; last_pop = '0;

    // reset values
    #12;
    chk("rst_empty", s_empty, 1); chk("rst_full", s_full, 0); chk("rst_cnt", s_cnt, 0);
    chk("rst_ae", s_ae, 1); chk("rst_af", s_af, 0); chk("rst_dout", s_dout, 0);
    chk("rst_ovf", s_ovf, 0); chk("rst_udf", s_udf, 0);
    @(posedge clk); #3 rst = 1'b1;

    // AW=2 standard: fill, overflow, drain in order
    sel = 0;
    we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'hA0 + 8'(i);
      tick();
    end
    chk("fill_full", s_full, 1); chk("fill_cnt", s_cnt, 4); chk("fill_af", s_af, 1);
    chk("fill_empty", s_empty, 0);
    din = 8'hEE;
    tick();
    we = 1'b0;
    chk("ovf_set", s_ovf, 1); chk("ovf_cnt", s_cnt, 4); chk("ovf_full", s_full, 1);
    re = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    re = 1'b0;
    tick();
    chk("drain_empty", s_empty, 1); chk("drain_cnt", s_cnt, 0);
    chk("drain_ae", s_ae, 1); chk("drain_af", s_af, 0);
    tick();
    chk("dout_hold", s_dout, 8'hA3);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovf_clr", s_ovf, 0);
    re = 1'b1; tick(); re = 1'b0;
    chk("udf_std", s_udf, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("udf_std_clr", s_udf, 0);

    // AW=2 FWFT: first-word latency, pop, underflow / clr_err priority
    sel = 1;
    din = 8'h5C; we = 1'b1; tick(); we = 1'b0;
    chk("fwft_e0", s_empty, 1); chk("fwft_c0", s_cnt, 1);
    tick();
    chk("fwft_e1", s_empty, 1);
    tick();
    chk("fwft_e2", s_empty, 0); chk("fwft_dout", s_dout, 8'h5C); chk("fwft_c2", s_cnt, 0);
    re = 1'b1; tick(); re = 1'b0;
    chk("fwft_pop_empty", s_empty, 1); chk("fwft_pop_cnt", s_cnt, 0);
    chk("fwft_pop_udf", s_udf, 0);
    re = 1'b1; tick();
    chk("udf_set", s_udf, 1);
    clr_err = 1'b1; tick(); re = 1'b0;
    chk("udf_prio", s_udf, 1);
    tick(); clr_err = 1'b0;
    chk("udf_clr", s_udf, 0);

    // AW=3 standard: steady stream at cnt=3 across wrap, then fill + flush
    sel = 2;
    we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'($urandom_range(0, 255));
      tick();
    end
    chk("s3_cnt", s_cnt, 3); chk("s3_ae", s_ae, 0);
    re = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din = 8'($urandom_range(0, 255));
      tick();
      chk("s3_run_cnt", s_cnt, 3); chk("s3_run_full", s_full, 0);
      chk("s3_run_ovf", s_ovf, 0); chk("s3_run_udf", s_udf, 0);
    end
    re = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din = 8'($urandom_range(0, 255));
      tick();
    end
    chk("pre_flush_cnt", s_cnt, 5);
    re = 1'b1; flush = 1'b1; din = 8'h77;
    tick();
    flush = 1'b0; we = 1'b0; re = 1'b0;
    chk("flush_cnt", s_cnt, 0); chk("flush_empty", s_empty, 1); chk("flush_full", s_full, 0);
    chk("flush_dout", s_dout, last_pop); chk("flush_udf", s_udf, 0);
    tick();
    chk("flush_nowr", s_cnt, 0);

    // AW=3 FWFT: steady stream at cnt=3, fill to 6, async reset mid-burst
    sel = 3;
    we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'($urandom_range(0, 255));
      tick();
    end
    we = 1'b0;
    tick();
    chk("f3_cnt", s_cnt, 3); chk("f3_empty", s_empty, 0);
    we = 1'b1; re = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din = 8'($urandom_range(0, 255));
      tick();
      chk("f3_run_cnt", s_cnt, 3); chk("f3_run_empty", s_empty, 0);
      chk("f3_run_ovf", s_ovf, 0); chk("f3_run_udf", s_udf, 0);
    end
    re = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 8'($urandom_range(0, 255));
      tick();
    end
    chk("f3_cnt6", s_cnt, 6); chk("f3_af6", s_af, 1);
    din = 8'h99;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_cnt", s_cnt, 0); chk("arst_empty", s_empty, 1); chk("arst_full", s_full, 0);
    chk("arst_ae", s_ae, 1); chk("arst_af", s_af, 0); chk("arst_dout", s_dout, 0);
    chk("arst_ovf", s_ovf, 0); chk("arst_udf", s_udf, 0);
    @(posedge clk);
    #1 we = 1'b0;
    #2 rst = 1'b1;
    chk("arst_nowr", s_cnt, 0);
    din = 8'h3E; we = 1'b1; tick(); we = 1'b0;
    tick(); tick();
    chk("resume_empty", s_empty, 0); chk("resume_dout", s_dout, 8'h3E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
